controle_escrita_banco: RTL and testbench

- Write-back controller for the 16x16-bit three-read-port register file; owns its shared write/read-3 address port (entrada3), sinal and dado.
- Arbitrates N write-back requesters (default ALU, memory) onto the single write port.
- Multiplexes entrada3 between write-back and read port 3.
- Keeps a per-register pending scoreboard so decode stalls on RAW/WAW hazards.

---
 rtl/controle_pkg.sv | 9 +
 rtl/controle_escrita_banco_arbitro_rr.sv | 26 ++
 rtl/controle_escrita_banco.sv | 108 ++++++++++
 tb/tb_controle_escrita_banco.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// controle_pkg: shared sizes, requester indices and FSM state for the register-file write-back controller
package controle_pkg;
    localparam int NREG    = 16;
    localparam int AW      = 4;
    localparam int DW      = 16;
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    typedef enum logic {IDLE, WRITE} state_t;
endpackage

// File: rtl/controle_escrita_banco_arbitro_rr.sv
// arbitro_rr: one-hot grant among valid requesters; round-robin from ptr, or fixed lowest-index priority when WB_FIXED_PRIO_EN is defined
module arbitro_rr #(
    parameter int N  = 2
`ifndef WB_FIXED_PRIO_EN
    ,
    parameter int PW = 1
`endif
) (
    input  logic [N-1:0]  valid,
`ifndef WB_FIXED_PRIO_EN
    input  logic [PW-1:0] ptr,
`endif
    output logic [N-1:0]  grant
);
`ifdef WB_FIXED_PRIO_EN
    // isolate the lowest set valid bit
    always_comb grant = valid & (~valid + N'(1));
`else
    logic [N-1:0] upper;
    // prefer the lowest requester at or above ptr, otherwise wrap to the lowest overall
    always_comb begin
        upper = valid & ~((N'(1) << ptr) - N'(1));
        grant = (upper != '0) ? (upper & (~upper + N'(1))) : (valid & (~valid + N'(1)));
    end
`endif
endmodule

// File: rtl/controle_escrita_banco.sv
// controle_escrita_banco: write-back arbiter, entrada3 mux and pending-register scoreboard; WB_FIXED_PRIO_EN selects fixed priority
module controle_escrita_banco #(
    parameter int NREQ = 2,
    parameter int AW   = 4,
    parameter int DW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   wb_valid,
    input  logic [NREQ*AW-1:0] wb_addr,
    input  logic [NREQ*DW-1:0] wb_dado,
    output logic [NREQ-1:0]   wb_ready,
    input  logic              rd3_valid,
    input  logic [AW-1:0]     rd3_addr,
    output logic              rd3_ready,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    input  logic [AW-1:0]     src1_addr,
    input  logic [AW-1:0]     src2_addr,
    output logic              hazard,
    output logic              rf_sinal,
    output logic [AW-1:0]     rf_entrada3,
    output logic [DW-1:0]     rf_dado
);
    import controle_pkg::*;

    state_t                state_q, state_d;
    logic [AW-1:0]         rf_entrada3_q, rf_entrada3_d, sel_addr;
    logic [DW-1:0]         rf_dado_q, rf_dado_d, sel_dado;
    logic [(1<<AW)-1:0]    pending_q, pending_d;
    logic [NREQ-1:0]       grant;
    logic                  xfer;

`ifdef WB_FIXED_PRIO_EN
    arbitro_rr #(.N(NREQ)) u_arb (.valid(wb_valid), .grant(grant));
`else
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [PW-1:0] ptr_q, ptr_d;
    arbitro_rr #(.N(NREQ), .PW(PW)) u_arb (.valid(wb_valid), .ptr(ptr_q), .grant(grant));
`endif

    assign wb_ready  = reset ? '0 : grant;
    assign xfer      = !reset && (grant != '0);
    assign rd3_ready = !reset && rd3_valid && (wb_valid == '0);
    assign hazard    = !reset && (pending_q[src1_addr] | pending_q[src2_addr] | (rsv_valid & pending_q[rsv_addr]));

    // route the granted requester's address/data and compute the pointer slot after it
    always_comb begin
        sel_addr = '0;
        sel_dado = '0;
`ifndef WB_FIXED_PRIO_EN
        ptr_d = ptr_q;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = wb_addr[i*AW +: AW];
                sel_dado = wb_dado[i*DW +: DW];
`ifndef WB_FIXED_PRIO_EN
                ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
`endif
            end
        end
    end

    // a write is staged for exactly the cycle after each accepted transfer
    always_comb state_d = xfer ? WRITE : IDLE;

    // stage write or read-3 address; scoreboard clears first so a same-edge reservation wins
    always_comb begin
        rf_entrada3_d = xfer ? sel_addr : rd3_addr;
        rf_dado_d     = xfer ? sel_dado : rf_dado_q;
        pending_d     = pending_q;
        if (xfer) pending_d[sel_addr] = 1'b0;
        if (rsv_valid && !hazard) pending_d[rsv_addr] = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // staging registers, scoreboard and arbitration pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_entrada3_q <= '0;
            rf_dado_q     <= '0;
            pending_q     <= '0;
`ifndef WB_FIXED_PRIO_EN
            ptr_q         <= '0;
`endif
        end else begin
            rf_entrada3_q <= rf_entrada3_d;
            rf_dado_q     <= rf_dado_d;
            pending_q     <= pending_d;
`ifndef WB_FIXED_PRIO_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    // register-file drive: write enable follows the FSM state
    always_comb begin
        rf_sinal    = (state_q == WRITE);
        rf_entrada3 = rf_entrada3_q;
        rf_dado     = rf_dado_q;
    end
endmodule

// File: tb/tb_controle_escrita_banco.sv
// tb_controle_escrita_banco: scoreboard bench for the write-back controller (both WB_FIXED_PRIO_EN builds)
module tb_controle_escrita_banco;
    localparam int NREQ = 2;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   wb_valid = '0;
    logic [NREQ*4-1:0] wb_addr = '0;
    logic [NREQ*16-1:0] wb_dado = '0;
    logic [NREQ-1:0]   wb_ready;
    logic              rd3_valid = 1'b0;
    logic [3:0]        rd3_addr = '0;
    logic              rd3_ready;
    logic              rsv_valid = 1'b0;
    logic [3:0]        rsv_addr = '0;
    logic [3:0]        src1_addr = '0;
    logic [3:0]        src2_addr = '0;
    logic              hazard;
    logic              rf_sinal;
    logic [3:0]        rf_entrada3;
    logic [15:0]       rf_dado;

    int checks = 0;
    int errors = 0;

    wr_t        exp_q[$];
    logic [15:0] m_pend = '0;
    int          m_ptr = 0;
    logic        m_sinal = 1'b0;
    logic [3:0]  m_e3 = '0;

    controle_escrita_banco #(.NREQ(NREQ), .AW(4), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_dado(wb_dado), .wb_ready(wb_ready),
        .rd3_valid(rd3_valid), .rd3_addr(rd3_addr), .rd3_ready(rd3_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .src1_addr(src1_addr), .src2_addr(src2_addr), .hazard(hazard),
        .rf_sinal(rf_sinal), .rf_entrada3(rf_entrada3), .rf_dado(rf_dado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] model_grant();
        logic [NREQ-1:0] g;
        int s;
        int k;
        g = '0;
        s = 0;
`ifndef WB_FIXED_PRIO_EN
        s = m_ptr;
`endif
        if (!reset)
            for (int i = 0; i < NREQ; i++) begin
                k = (s + i) % NREQ;
                if (g == '0 && wb_valid[k]) g[k] = 1'b1;
            end
        return g;
    endfunction

    task automatic idle_in();
        wb_valid = '0; rd3_valid = 1'b0; rsv_valid = 1'b0;
        src1_addr = '0; src2_addr = '0; rsv_addr = '0;
    endtask

    task automatic cycle();
        logic [NREQ-1:0] g;
        logic hz;
        wr_t w;
        @(negedge clk);
        g  = model_grant();
        hz = !reset && (m_pend[src1_addr] | m_pend[src2_addr] | (rsv_valid & m_pend[rsv_addr]));
        chk("wb_ready", wb_ready, g);
        chk("rd3_ready", rd3_ready, !reset && rd3_valid && (wb_valid == '0));
        chk("hazard", hazard, hz);
        chk("rf_sinal", rf_sinal, m_sinal);
        if (m_sinal && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("wr_entrada3", rf_entrada3, w.a);
            chk("wr_dado", rf_dado, w.d);
        end else if (!m_sinal) begin
            chk("rd_entrada3", rf_entrada3, m_e3);
        end
        @(posedge clk);
        if (reset) begin
            m_pend = '0; m_ptr = 0; m_sinal = 1'b0; m_e3 = '0;
            exp_q.delete();
        end else begin
            m_sinal = |g;
            m_e3 = rd3_addr;
            for (int i = 0; i < NREQ; i++)
                if (g[i]) begin
                    w.a = wb_addr[i*4 +: 4];
                    w.d = wb_dado[i*16 +: 16];
                    exp_q.push_back(w);
                    m_pend[w.a] = 1'b0;
                    m_ptr = (i + 1) % NREQ;
                    m_e3 = w.a;
                end
            if (rsv_valid && !hz) m_pend[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        cycle(); cycle();
        chk("rst_dado", rf_dado, 0);
        reset = 1'b0;
        // single write to register 5
        wb_valid = 2'b01; wb_addr = {4'd0, 4'd5}; wb_dado = {16'h0000, 16'hABCD};
        cycle();
        chk("single_sinal", rf_sinal, 1);
        chk("single_addr", rf_entrada3, 5);
        wb_valid = '0;
        cycle(); cycle();
        // contention from a fresh pointer
        reset = 1'b1; cycle(); reset = 1'b0;
        wb_valid = 2'b11; wb_addr = {4'd7, 4'd3}; wb_dado = {16'h7777, 16'h3333};
        repeat (4) cycle();
        wb_valid = '0; cycle();
        // scoreboard set and clear on register 9
        rsv_valid = 1'b1; rsv_addr = 4'd9; cycle();
        rsv_valid = 1'b0; src1_addr = 4'd9; cycle();
        chk("hz9_set", hazard, 1);
        wb_valid = 2'b10; wb_addr = {4'd9, 4'd0}; wb_dado = {16'h0909, 16'h0000}; cycle();
        wb_valid = '0; #1;
        chk("hz9_clr", hazard, 0);
        cycle();
        // same-edge reserve and write-back on register 4
        src1_addr = '0; rsv_valid = 1'b1; rsv_addr = 4'd4;
        wb_valid = 2'b01; wb_addr = {4'd0, 4'd4}; wb_dado = {16'h0000, 16'h4444}; cycle();
        rsv_valid = 1'b0; wb_valid = '0; src1_addr = 4'd4; #1;
        chk("hz4_set_wins", hazard, 1);
        cycle();
        // read port 3 loses to write-back, then wins
        src1_addr = '0; rd3_valid = 1'b1; rd3_addr = 4'd2;
        wb_valid = 2'b10; wb_addr = {4'd6, 4'd0}; wb_dado = {16'h6666, 16'h0000}; cycle();
        wb_valid = '0; cycle();
        rd3_valid = 1'b0; cycle();
        chk("rd3_addr2", rf_entrada3, 2);
        // random traffic with occasional reset
        repeat (300) begin
            wb_valid  = NREQ'($urandom);
            wb_addr   = 8'($urandom);
            wb_dado   = $urandom;
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_addr  = 4'($urandom);
            src1_addr = 4'($urandom);
            src2_addr = 4'($urandom);
            rd3_valid = 1'($urandom);
            rd3_addr  = 4'($urandom);
            reset     = ($urandom_range(0, 49) == 0);
            cycle();
        end
        // reset while a write is staged and registers are pending
        reset = 1'b0; idle_in();
        rsv_valid = 1'b1; rsv_addr = 4'd3; cycle();
        rsv_addr = 4'd11; cycle();
        rsv_valid = 1'b0;
        wb_valid = 2'b01; wb_addr = {4'd0, 4'd12}; wb_dado = {16'h0000, 16'h1234}; cycle();
        wb_valid = '0; reset = 1'b1; cycle();
        chk("rst_mid_sinal", rf_sinal, 0);
        chk("rst_mid_dado", rf_dado, 0);
        chk("rst_mid_e3", rf_entrada3, 0);
        reset = 1'b0;
        for (int s = 0; s < 16; s++) begin
            src1_addr = 4'(s);
            src2_addr = 4'(15 - s);
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
